// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
//
// Purpose:
//   Writer side of the instruction-memory write port of the pipelined core.
//   It takes a byte stream over a valid/ready handshake. The first four bytes
//   form a little-endian word count N. The next N groups of four bytes form
//   the instruction words. Each word goes to consecutive instruction-memory
//   addresses starting at BASE_ADDR. The core is held while a load is in
//   progress. A sticky done or err flag reports how the load ended.
//
// Handshake:
//   A byte moves on a rising edge where byte_valid_i and byte_ready_o are
//   both high. byte_ready_o is high only while the loader expects a byte
//   (states LEN and DATA). byte_valid_i is ignored while byte_ready_o is low.
//
// Ports:
//   clk              system clock, rising-edge
//   reset            asynchronous, active-low reset
//   start_i          one-cycle load request (honoured in IDLE, DONE and ERR)
//   byte_valid_i     byte_data_i carries a byte
//   byte_data_i      stream byte
//   byte_ready_o     loader accepts a byte this cycle
//   wr_en_imem_o     one-cycle instruction-memory write strobe
//   wr_addr_imem_o   write byte address (holds its last value between writes)
//   wr_instr_imem_o  write data word (holds its last value between writes)
//   core_hold_o      core must stay stalled while high
//   done_o           last load finished cleanly (sticky until next start)
//   err_o            last load aborted (sticky until next start)
//   words_loaded_o   words written by the current or last load
//   state_o          current FSM state, for debug and checkers

module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [15:0] TIMEOUT   = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wr_en_imem_o,
    output logic [31:0] wr_addr_imem_o,
    output logic [31:0] wr_instr_imem_o,
    output logic        core_hold_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_loaded_o,
    output logic [2:0]  state_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    logic [2:0]  state;
    logic [1:0]  byte_idx;
    logic [15:0] word_cnt;
    logic [15:0] n_words;
    logic [15:0] tmo_cnt;
    logic [31:0] asm_word;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_instr_q;

    logic        accept;
    logic        start_ok;
    logic        last_byte;
    logic [31:0] new_word;

    assign byte_ready_o = (state == LEN) || (state == DATA);
    assign accept       = byte_valid_i && byte_ready_o;
    assign start_ok     = start_i && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign last_byte    = (byte_idx == 2'd3);
    // The incoming byte enters at the top and older bytes shift down. After
    // four bytes, the first byte sits in [7:0], which gives little-endian order.
    assign new_word     = {byte_data_i, asm_word[31:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            word_cnt   <= 16'd0;
            n_words    <= 16'd0;
            tmo_cnt    <= 16'd0;
            asm_word   <= 32'd0;
            wr_addr_q  <= 32'd0;
            wr_instr_q <= 32'd0;
        end else if (start_ok) begin
            state    <= LEN;
            byte_idx <= 2'd0;
            word_cnt <= 16'd0;
            tmo_cnt  <= 16'd0;
            asm_word <= 32'd0;
        end else begin
            case (state)
                LEN, DATA: begin
                    if (accept) begin
                        tmo_cnt  <= 16'd0;
                        asm_word <= new_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            if (state == LEN) begin
                                if (new_word == 32'd0) begin
                                    state <= DONE;
                                end else if (new_word > 32'(MAX_WORDS)) begin
                                    state <= ERR;
                                end else begin
                                    n_words  <= new_word[15:0];
                                    word_cnt <= 16'd0;
                                    state    <= DATA;
                                end
                            end else begin
                                // Address and data are registered here so
                                // they are stable for the whole WRITE cycle.
                                // They then hold until the next word.
                                wr_addr_q  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                                wr_instr_q <= new_word;
                                state      <= WRITE;
                            end
                        end
                    end else if (tmo_cnt == TIMEOUT - 16'd1) begin
                        // This is the TIMEOUT-th consecutive idle edge.
                        state <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    if (word_cnt + 16'd1 == n_words) begin
                        state <= DONE;
                    end else begin
                        state <= DATA;
                    end
                end
                IDLE, DONE, ERR: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wr_en_imem_o    = (state == WRITE);
    assign wr_addr_imem_o  = wr_addr_q;
    assign wr_instr_imem_o = wr_instr_q;
    assign core_hold_o     = (state == LEN) || (state == DATA) || (state == WRITE);
    assign done_o          = (state == DONE);
    assign err_o           = (state == ERR);
    assign words_loaded_o  = word_cnt;
    assign state_o         = state;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Bench for imem_loader: a byte-stream driver, a write scoreboard fed from a
// word-level model of the program, and one task per scenario.

module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o;
    logic        wr_en_imem_o;
    logic [31:0] wr_addr_imem_o;
    logic [31:0] wr_instr_imem_o;
    logic        core_hold_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_loaded_o;
    logic [2:0]  state_o;

    imem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .TIMEOUT   (16'd8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .byte_valid_i    (byte_valid_i),
        .byte_data_i     (byte_data_i),
        .byte_ready_o    (byte_ready_o),
        .wr_en_imem_o    (wr_en_imem_o),
        .wr_addr_imem_o  (wr_addr_imem_o),
        .wr_instr_imem_o (wr_instr_imem_o),
        .core_hold_o     (core_hold_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .words_loaded_o  (words_loaded_o),
        .state_o         (state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang exp finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];      // {addr, data} of each expected write
    logic [31:0] words_q[$];    // program words of the current load
    logic [7:0]  bytes_q[$];    // stream bytes of the current load
    logic [63:0] exp_e;
    int          wr_pulses = 0;
    int          hold_cycles = 0;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (core_hold_o) hold_cycles++;
        if (wr_en_imem_o) begin
            wr_pulses++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: got addr=%h data=%h, exp no write",
                         wr_addr_imem_o, wr_instr_imem_o);
            end else begin
                exp_e = exp_q.pop_front();
                if ({wr_addr_imem_o, wr_instr_imem_o} !== exp_e) begin
                    miscompares++;
                    $display("FAIL sb_write: got addr=%h data=%h, exp addr=%h data=%h",
                             wr_addr_imem_o, wr_instr_imem_o, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    // ---------------- model helpers ----------------
    // Stream = 4-byte little-endian count, then each word little-endian.
    task automatic build_stream(input logic [31:0] n);
        bytes_q.delete();
        for (int k = 0; k < 4; k++) bytes_q.push_back(8'((n >> (8 * k)) & 32'hFF));
        for (int i = 0; i < words_q.size(); i++)
            for (int k = 0; k < 4; k++) bytes_q.push_back(8'((words_q[i] >> (8 * k)) & 32'hFF));
    endtask

    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(i) * 32'd4, words_q[i]});
    endtask

    task automatic random_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // ---------------- drivers ----------------
    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
        int w;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            start_i = 1'b0;
        end
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        start_i      = pulse_start;
        w = 0;
        while (!byte_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready_o) begin
            miscompares++;
            $display("FAIL send_byte_ready: got ready=0 exp ready=1 for byte %h", b);
        end
        @(posedge clk);
    endtask

    task automatic stream_load(input int first, input int count, input int max_gap, input int start_at);
        for (int k = first; k < first + count; k++)
            send_byte(bytes_q[k], $urandom_range(0, max_gap), (k == start_at));
        @(negedge clk);
        byte_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done_o || err_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        byte_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({byte_ready_o, wr_en_imem_o, core_hold_o, done_o, err_o} !== 5'b0 ||
            wr_addr_imem_o !== 32'd0 || wr_instr_imem_o !== 32'd0 || words_loaded_o !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b hold=%b done=%b err=%b addr=%h data=%h words=%0d exp all 0",
                     byte_ready_o, wr_en_imem_o, core_hold_o, done_o, err_o,
                     wr_addr_imem_o, wr_instr_imem_o, words_loaded_o);
        end
        byte_valid_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (byte_ready_o !== 1'b0 || core_hold_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got rdy=%b hold=%b exp 0 0", byte_ready_o, core_hold_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        words_q = '{32'h0000_0013, 32'h1234_5678};
        build_stream(32'd2);
        expect_words(2);
        do_start();
        @(negedge clk);
        start_i = 1'b0;
        vectors++;
        if (core_hold_o !== 1'b1 || byte_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_hold_after_start: got hold=%b rdy=%b exp 1 1", core_hold_o, byte_ready_o);
        end
        stream_load(0, bytes_q.size(), 0, -1);
        wait_end(ok);
        vectors++;
        if (!ok || done_o !== 1'b1 || err_o !== 1'b0 || core_hold_o !== 1'b0 || words_loaded_o !== 16'd2) begin
            miscompares++;
            $display("FAIL basic_end: got done=%b err=%b hold=%b words=%0d exp 1 0 0 2",
                     done_o, err_o, core_hold_o, words_loaded_o);
        end
        vectors++;
        if (exp_q.size() != 0 || wr_addr_imem_o !== 32'h4 || wr_instr_imem_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL basic_writes: got pending=%0d addr=%h data=%h exp 0 00000004 12345678",
                     exp_q.size(), wr_addr_imem_o, wr_instr_imem_o);
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        int h0, p0;
        words_q.delete();
        build_stream(32'd0);
        h0 = hold_cycles;
        p0 = wr_pulses;
        do_start();
        stream_load(0, 4, 0, -1);
        wait_end(ok);
        vectors++;
        if (!ok || done_o !== 1'b1 || err_o !== 1'b0 || words_loaded_o !== 16'd0) begin
            miscompares++;
            $display("FAIL zero_len_done: got done=%b err=%b words=%0d exp 1 0 0", done_o, err_o, words_loaded_o);
        end
        vectors++;
        if (hold_cycles - h0 != 4 || wr_pulses != p0) begin
            miscompares++;
            $display("FAIL zero_len_hold: got hold_cycles=%0d writes=%0d exp 4 0", hold_cycles - h0, wr_pulses - p0);
        end
    endtask

    task automatic test_too_long();
        bit ok;
        int p0;
        words_q.delete();
        build_stream(32'd1025);
        p0 = wr_pulses;
        do_start();
        @(negedge clk);
        start_i = 1'b0;
        vectors++;
        if (done_o !== 1'b0 || core_hold_o !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clears_done: got done=%b hold=%b exp 0 1", done_o, core_hold_o);
        end
        stream_load(0, 4, 0, -1);
        wait_end(ok);
        vectors++;
        if (!ok || err_o !== 1'b1 || done_o !== 1'b0 || byte_ready_o !== 1'b0 || core_hold_o !== 1'b0) begin
            miscompares++;
            $display("FAIL too_long_err: got err=%b done=%b rdy=%b hold=%b exp 1 0 0 0",
                     err_o, done_o, byte_ready_o, core_hold_o);
        end
        byte_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid_i = 1'b0;
        vectors++;
        if (wr_pulses != p0 || err_o !== 1'b1 || byte_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL too_long_stays: got writes=%0d err=%b rdy=%b exp 0 1 0", wr_pulses - p0, err_o, byte_ready_o);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit exp_err;
        // Eight idle edges after the 2nd data byte abort the load.
        random_words(1);
        build_stream(32'd1);
        do_start();
        stream_load(0, 6, 0, -1);   // header + 2 data bytes; last call drops valid
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk);
            exp_err = (i == 9);
            vectors++;
            if (err_o !== exp_err) begin
                miscompares++;
                $display("FAIL timeout_idle_%0d: got err=%b exp %b", i, err_o, exp_err);
            end
        end
        vectors++;
        if (core_hold_o !== 1'b0 || words_loaded_o !== 16'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_state: got hold=%b words=%0d pending=%0d exp 0 0 0",
                     core_hold_o, words_loaded_o, exp_q.size());
        end
        // Byte arriving on the 8th idle edge wins over the timeout.
        random_words(1);
        build_stream(32'd1);
        expect_words(1);
        do_start();
        for (int k = 0; k < 6; k++) send_byte(bytes_q[k], 0, 1'b0);
        send_byte(bytes_q[6], 7, 1'b0);
        send_byte(bytes_q[7], 0, 1'b0);
        @(negedge clk);
        byte_valid_i = 1'b0;
        wait_end(ok);
        vectors++;
        if (!ok || done_o !== 1'b1 || err_o !== 1'b0 || words_loaded_o !== 16'd1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_edge_byte: got done=%b err=%b words=%0d pending=%0d exp 1 0 1 0",
                     done_o, err_o, words_loaded_o, exp_q.size());
        end
    endtask

    task automatic test_gaps_mid_start();
        bit ok;
        words_q = '{32'h0000_0013, 32'h1234_5678};
        build_stream(32'd2);
        expect_words(2);
        do_start();
        stream_load(0, bytes_q.size(), 6, 5);
        wait_end(ok);
        vectors++;
        if (!ok || done_o !== 1'b1 || words_loaded_o !== 16'd2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL gaps_mid_start: got done=%b words=%0d pending=%0d exp 1 2 0",
                     done_o, words_loaded_o, exp_q.size());
        end
    endtask

    task automatic test_random_loads();
        bit ok;
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 9);
            random_words(n);
            build_stream(32'(n));
            expect_words(n);
            do_start();
            stream_load(0, bytes_q.size(), 6, $urandom_range(4, 6));
            wait_end(ok);
            vectors++;
            if (!ok || done_o !== 1'b1 || words_loaded_o !== 16'(n) || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL random_load_%0d: got done=%b words=%0d pending=%0d exp 1 %0d 0",
                         r, done_o, words_loaded_o, exp_q.size(), n);
            end
        end
    endtask

    task automatic test_max_words();
        bit ok;
        random_words(MAXW);
        build_stream(32'(MAXW));
        expect_words(MAXW);
        do_start();
        stream_load(0, bytes_q.size(), 0, -1);
        wait_end(ok);
        vectors++;
        if (!ok || done_o !== 1'b1 || err_o !== 1'b0 || words_loaded_o !== 16'(MAXW) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL max_words: got done=%b err=%b words=%0d pending=%0d exp 1 0 %0d 0",
                     done_o, err_o, words_loaded_o, exp_q.size(), MAXW);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        random_words(3);
        build_stream(32'd3);
        expect_words(1);            // only word 0 lands before reset
        p0 = wr_pulses;
        do_start();
        for (int k = 0; k < 10; k++) send_byte(bytes_q[k], 0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({byte_ready_o, wr_en_imem_o, core_hold_o, done_o, err_o} !== 5'b0 ||
            wr_addr_imem_o !== 32'd0 || wr_instr_imem_o !== 32'd0 || words_loaded_o !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got rdy=%b wr=%b hold=%b done=%b err=%b addr=%h data=%h words=%0d exp all 0",
                     byte_ready_o, wr_en_imem_o, core_hold_o, done_o, err_o,
                     wr_addr_imem_o, wr_instr_imem_o, words_loaded_o);
        end
        repeat (3) @(negedge clk);
        byte_valid_i = 1'b0;
        reset = 1'b1;
        vectors++;
        if (wr_pulses - p0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_writes: got writes=%0d pending=%0d exp 1 0", wr_pulses - p0, exp_q.size());
        end
        random_words(1);
        build_stream(32'd1);
        expect_words(1);
        do_start();
        stream_load(0, bytes_q.size(), 2, -1);
        wait_end(ok);
        vectors++;
        if (!ok || done_o !== 1'b1 || wr_addr_imem_o !== BASE || wr_instr_imem_o !== words_q[0] || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_reload: got done=%b addr=%h data=%h pending=%0d exp 1 %h %h 0",
                     done_o, wr_addr_imem_o, wr_instr_imem_o, exp_q.size(), BASE, words_q[0]);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_gaps_mid_start();
        test_random_loads();
        test_max_words();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory write port (wr_instr / wr_en) of the pipelined MIPS core.
- Receives a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
- Writes each word to consecutive instruction-memory addresses.
- Holds the core (core_hold_o) while a program load is in progress and reports completion or error.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 1024, largest accepted word count; a larger header count is an error.
- TIMEOUT, 65535, idle cycles allowed between accepted bytes during a load before aborting (counter is 16 bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle load request.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  incoming stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- wr_en_imem_o  output  1  instruction-memory write enable, one-cycle pulse.
- wr_addr_imem_o  output  32  write byte address.
- wr_instr_imem_o  output  32  write data word.
- core_hold_o  output  1  core must stay in reset/stalled while high.
- done_o  output  1  load completed successfully; sticky until the next start.
- err_o  output  1  load aborted; sticky until the next start.
- words_loaded_o  output  16  number of words written in the current or last load.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; byte index, word index, timeout counter and assembly register all cleared.
- Reset asserted mid-load: same as above. Words already written stay in memory. No write is issued after reset assertion.
- Byte handshake: a byte is accepted when byte_valid_i and byte_ready_o are both high in the same cycle.
  - byte_ready_o is high only in states LEN and DATA.
  - Byte k (0..3) of a group goes into bits [8k+7:8k], little-endian.
- Stream format: 4-byte word count N, then N groups of 4 bytes.
- IDLE: start_i -> LEN. On entry, clear done_o, err_o, words_loaded_o, the indices and the timeout counter.
- LEN: on the 4th accepted byte:
  - N == 0 -> DONE.
  - N > MAX_WORDS -> ERR.
  - otherwise -> DATA, with word index set to 0.
- DATA: on the 4th accepted byte, latch the word -> WRITE.
- WRITE (exactly one cycle):
  - wr_en_imem_o = 1.
  - wr_addr_imem_o = BASE_ADDR + 4*index, computed modulo 2^32 (wrap permitted).
  - wr_instr_imem_o = assembled word.
  - index increments and words_loaded_o increments.
  - Then index == N -> DONE, else -> DATA.
- Data-to-write latency: the write pulse occurs in the cycle after the 4th byte of a word is accepted.
- Bus idle values: wr_addr_imem_o and wr_instr_imem_o hold their last values outside WRITE. wr_en_imem_o is 0 in every state except WRITE.
- Timeout (LEN and DATA only):
  - Counter clears on each accepted byte and on entry to LEN; otherwise increments by 1.
  - When the counter reaches TIMEOUT with no byte accepted in that cycle -> ERR.
  - A byte accepted in the same cycle the counter reaches TIMEOUT wins; no error.
- DONE: done_o = 1. ERR: err_o = 1. Both states stay put until start_i, then go to LEN (a restart).
- start_i in LEN, DATA or WRITE is ignored.
- core_hold_o = 1 in LEN, DATA and WRITE; 0 in IDLE, DONE and ERR. It rises the cycle after start_i is accepted and falls in the same cycle done_o or err_o rises.
- byte_valid_i while byte_ready_o is low is ignored; no byte is consumed.

Test Plan:
1. Reset, start, stream 02 00 00 00 | 13 00 00 00 | 78 56 34 12 with valid held high -> two write pulses:
   - addr 0x0, data 0x00000013;
   - addr 0x4, data 0x12345678.
   - Then done_o = 1, core_hold_o = 0, words_loaded_o = 2.
2. Header 00 00 00 00 -> DONE with no wr_en pulse; core_hold_o high for exactly the 4 byte-accept cycles.
3. Header 0x00000401 with MAX_WORDS = 1024 -> err_o = 1 after the 4th byte, no writes, byte_ready_o = 0 afterwards.
4. TIMEOUT = 8: after N = 1 and 2 data bytes, hold valid low -> err_o rises 8 idle cycles later.
   - Repeat, but present the 3rd byte on exactly that 8th cycle -> no error.
5. Random valid gaps (below the timeout) and a start_i pulse mid-load -> written words and addresses are identical to scenario 1; the start is ignored.
6. Pull reset low during DATA after one word is written -> all outputs 0 immediately.
   - Release reset, start, and load N = 1 -> write at BASE_ADDR; done_o = 1.
